pattern_generator: RTL and testbench
====================================

Name: pattern_generator

Overview:
- Parametrised multi-mode video test-pattern source for the HDMI output path. Emits one beat of LANES pixels per accepted ready/valid transfer, scanning a full frame per start_frame request.
- Successor to the fixed 4-lane bouncing-box generator. Adds:
  - selectable modes;
  - a configurable lane count and pixel width;
  - start-of-frame and end-of-line flags;
  - a frame counter.
- Sits between the frame-timing controller (start_frame) and the TMDS encoder FIFO (ready/valid).

Parameters:
LANES, 4, pixels per output beat (1..8).
PIXEL_BITS, 24, bits per pixel; RGB packed {R,G,B} in bits [23:0], upper bits zero.
BOX_SIZE, 200, bouncing-box edge length in pixels.
BOX_STEP, 8, box displacement per frame in x and y.
BORDER, 20, minimum box distance from frame edge.
BAR_SHIFT, 5, colour-bar width = 2^BAR_SHIFT pixels.

Ports:
clock  in  1  sole clock.
reset_n  in  1  asynchronous active-low reset.
video_width  in  16  active pixels per line. Must be >= LANES; stable while busy.
video_height  in  16  active lines per frame. Must be >= 1; stable while busy.
mode  in  2  0 solid, 1 colour bars, 2 checkerboard, 3 checkerboard + bouncing box. Sampled at frame start.
solid_colour  in  24  colour for mode 0. Sampled at frame start.
check_shift  in  3  checker square = 2^check_shift pixels. Sampled at frame start.
ring_enable  in  1  draw 4-pixel calibration ring (blue, green, red, black, outermost first). Sampled at frame start.
start_frame  in  1  request a new frame; ignored while busy.
busy  out  1  frame scan in progress.
ready  in  1  downstream accepts beat.
valid  out  1  beat present.
data  out  LANES*PIXEL_BITS  lane i in bits [i*PIXEL_BITS +: PIXEL_BITS]; lane 0 = leftmost pixel.
sof  out  1  beat is first of frame (x=0, y=0).
eol  out  1  beat is last of line.
frame_count  out  16  completed frames; wraps at 65535->0.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - valid=0, busy=0, sof=0, eol=0, data=0, frame_count=0.
  - Box position bx=by=BORDER, direction dx=dy=0 (increasing).
- Advance condition: adv = ready | ~valid. Output register and position counters update only when adv.
- States:
  - IDLE: on start_frame=1, latch mode/solid_colour/check_shift/ring_enable, set cx=cy=0, go SCAN; busy=1 from the next cycle.
  - SCAN: each adv cycle, register the beat for (cx..cx+LANES-1, cy) with valid=1, then advance:
    - cx+LANES < video_width: cx+=LANES.
    - otherwise cx=0.
      - cy+1 < video_height: cy+=1.
      - cy+1 >= video_height (last beat): go IDLE, frame_count+=1, update box.
  - IDLE with adv: valid<=0.
- Latency: start_frame in cycle N (IDLE, ready=1) -> valid=1 with sof=1 in cycle N+2. With ready held high there are no bubbles within a frame. A new start_frame in the cycle busy falls can produce back-to-back frames with a one-cycle gap.
- Backpressure: while valid=1 & ready=0, data/sof/eol/valid hold stable and counters freeze.
- Flags:
  - sof=1 only on beat (0,0).
  - eol=1 on a beat with cx+LANES >= video_width.
- Width not a multiple of LANES: lanes with x >= video_width output 0.
- Per-pixel colour priority (x,y = lane coordinates, all compares 16-bit unsigned; 17-bit intermediates for sums):
  1. Ring: if ring_enable and min(x, y, W-1-x, H-1-y) = k < 4, output the ring colour for k.
  2. Box: mode 3 and bx<=x<bx+BOX_SIZE and by<=y<by+BOX_SIZE -> FFCC66.
  3. Mode 0: solid_colour.
  4. Mode 1: bar index (x>>BAR_SHIFT) mod 8 selects white, yellow, cyan, green, magenta, red, blue, black.
  5. Modes 2/3: x[check_shift]^y[check_shift] ? FFFFFF : CCCCCC.
- Box update at frame end (x shown; y identical with H/by/dy):
  - dx=0: if bx+STEP+BOX_SIZE+BORDER <= W then bx+=STEP, else bx-=STEP and dx=1.
  - dx=1: if bx >= BORDER+STEP then bx-=STEP, else bx+=STEP and dx=0.
  - Degenerate frame (W < BOX_SIZE+2*BORDER+STEP): bx is held at BORDER.
- Reset mid-frame: everything returns to reset values immediately; the partial frame is not counted.

Decomposition:
- Shared package hdmi_pkg:
  - RGB colour constants (bar palette, ring colours, box colour, checker colours);
  - mode encoding localparams;
  - pixel packing helper.
- Sub-module pattern_pixel (combinational): x, y, frame geometry, latched config, box position -> one pixel. Instantiated LANES times in a generate loop. Top holds the FSM, counters, box state and output register.

Test Plan:
- Reset, W=8, H=2, LANES=4, mode 0, solid 123456, start_frame, ready=1 -> 4 beats, all lanes 123456. sof on beat 0; eol on beats 1 and 3; frame_count=1; busy low after the last beat.
- W=64, H=1, mode 1, BAR_SHIFT=5, ring off -> pixels 0..31 FFFFFF, 32..63 FFFF00.
- W=10, H=1, LANES=4, mode 2 -> 3 beats; beat 2 lanes 2,3 = 0; eol only on beat 2.
- Mode 3, W=640, H=480, ring on, run 3 frames -> box at x=y=20/28/36, drawn FFCC66. Pixel (0,0)=0000FF, (1,5)=00FF00.
- Random ready deassertion during a frame -> output stable while stalled; beat sequence identical to the ready=1 run.
- Assert reset_n low mid-frame -> valid, busy and frame_count go 0 asynchronously. start_frame after release -> a fresh frame with sof on its first beat.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI test-pattern path: scan states, mode encoding,
// RGB palette and the helpers that map indices onto it.
package hdmi_pkg;

  typedef logic [23:0] rgb_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  localparam logic [1:0] MODE_SOLID       = 2'd0;
  localparam logic [1:0] MODE_BARS        = 2'd1;
  localparam logic [1:0] MODE_CHECKER     = 2'd2;
  localparam logic [1:0] MODE_CHECKER_BOX = 2'd3;

  function automatic rgb_t pack_rgb(input logic [7:0] r, input logic [7:0] g,
                                    input logic [7:0] b);
    return {r, g, b};
  endfunction

  localparam rgb_t COL_WHITE   = pack_rgb(8'hFF, 8'hFF, 8'hFF);
  localparam rgb_t COL_YELLOW  = pack_rgb(8'hFF, 8'hFF, 8'h00);
  localparam rgb_t COL_CYAN    = pack_rgb(8'h00, 8'hFF, 8'hFF);
  localparam rgb_t COL_GREEN   = pack_rgb(8'h00, 8'hFF, 8'h00);
  localparam rgb_t COL_MAGENTA = pack_rgb(8'hFF, 8'h00, 8'hFF);
  localparam rgb_t COL_RED     = pack_rgb(8'hFF, 8'h00, 8'h00);
  localparam rgb_t COL_BLUE    = pack_rgb(8'h00, 8'h00, 8'hFF);
  localparam rgb_t COL_BLACK   = pack_rgb(8'h00, 8'h00, 8'h00);
  localparam rgb_t COL_BOX     = pack_rgb(8'hFF, 8'hCC, 8'h66);
  localparam rgb_t COL_CHECK_A = pack_rgb(8'hFF, 8'hFF, 8'hFF);
  localparam rgb_t COL_CHECK_B = pack_rgb(8'hCC, 8'hCC, 8'hCC);

  function automatic rgb_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return COL_WHITE;
      3'd1:    return COL_YELLOW;
      3'd2:    return COL_CYAN;
      3'd3:    return COL_GREEN;
      3'd4:    return COL_MAGENTA;
      3'd5:    return COL_RED;
      3'd6:    return COL_BLUE;
      default: return COL_BLACK;
    endcase
  endfunction

  // Ring index 0 is the outermost pixel of the frame.
  function automatic rgb_t ring_colour(input logic [1:0] k);
    case (k)
      2'd0:    return COL_BLUE;
      2'd1:    return COL_GREEN;
      2'd2:    return COL_RED;
      default: return COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/pattern_pixel.sv
// Combinational colour of one pixel from its coordinates, the frame geometry,
// the configuration latched at frame start and the current box position.
module pattern_pixel
  import hdmi_pkg::*;
#(
  parameter int PIXEL_BITS = 24,
  parameter int BOX_SIZE   = 200,
  parameter int BAR_SHIFT  = 5
) (
  input  logic [15:0]           x,
  input  logic [15:0]           y,
  input  logic                  active,
  input  logic [15:0]           width,
  input  logic [15:0]           height,
  input  logic [1:0]            mode,
  input  logic [23:0]           solid_colour,
  input  logic [2:0]            check_shift,
  input  logic                  ring_enable,
  input  logic [15:0]           box_x,
  input  logic [15:0]           box_y,
  output logic [PIXEL_BITS-1:0] pixel
);

  logic [15:0] dist_right;
  logic [15:0] dist_bottom;
  logic [15:0] dist_near;
  logic [15:0] dist_far;
  logic [15:0] dist_min;
  logic        in_ring;
  logic        in_box;
  rgb_t        rgb;

  always_comb begin
    // Valid only for on-screen pixels; off-screen lanes are masked by active.
    dist_right  = width - 16'd1 - x;
    dist_bottom = height - 16'd1 - y;
    dist_near   = (x < y) ? x : y;
    dist_far    = (dist_right < dist_bottom) ? dist_right : dist_bottom;
    dist_min    = (dist_near < dist_far) ? dist_near : dist_far;
    in_ring     = ring_enable && (dist_min < 16'd4);

    in_box = (mode == MODE_CHECKER_BOX) &&
             (x >= box_x) && ({1'b0, x} < ({1'b0, box_x} + 17'(BOX_SIZE))) &&
             (y >= box_y) && ({1'b0, y} < ({1'b0, box_y} + 17'(BOX_SIZE)));

    rgb = COL_BLACK;
    if (in_ring) begin
      rgb = ring_colour(dist_min[1:0]);
    end else if (in_box) begin
      rgb = COL_BOX;
    end else if (mode == MODE_SOLID) begin
      rgb = solid_colour;
    end else if (mode == MODE_BARS) begin
      rgb = bar_colour(3'(x >> BAR_SHIFT));
    end else begin
      rgb = (x[check_shift] ^ y[check_shift]) ? COL_CHECK_A : COL_CHECK_B;
    end

    pixel = active ? PIXEL_BITS'(rgb) : '0;
  end

endmodule

// File: rtl/pattern_generator.sv
// Multi-mode video test-pattern source: scans one frame per start_frame request,
// emitting LANES pixels per ready/valid beat, and moves a bouncing box per frame.
module pattern_generator
  import hdmi_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int PIXEL_BITS = 24,
  parameter int BOX_SIZE   = 200,
  parameter int BOX_STEP   = 8,
  parameter int BORDER     = 20,
  parameter int BAR_SHIFT  = 5
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [15:0]                 video_width,
  input  logic [15:0]                 video_height,
  input  logic [1:0]                  mode,
  input  logic [23:0]                 solid_colour,
  input  logic [2:0]                  check_shift,
  input  logic                        ring_enable,
  input  logic                        start_frame,
  output logic                        busy,
  input  logic                        ready,
  output logic                        valid,
  output logic [LANES*PIXEL_BITS-1:0] data,
  output logic                        sof,
  output logic                        eol,
  output logic [15:0]                 frame_count
);

  // Handshake: a beat transfers on a cycle with valid & ready. The output register
  // and the scan counters advance only when the slot is free (ready | ~valid), so
  // a stalled beat holds data/sof/eol/valid stable until it is taken.

  scan_state_t state;
  logic [15:0] cx;
  logic [15:0] cy;
  logic [1:0]  cfg_mode;
  logic [23:0] cfg_solid;
  logic [2:0]  cfg_check_shift;
  logic        cfg_ring;
  logic [15:0] box_x;
  logic [15:0] box_y;
  logic        dir_x;
  logic        dir_y;

  logic                        adv;
  logic                        line_end;
  logic                        frame_end;
  logic [LANES*PIXEL_BITS-1:0] beat;

  assign adv       = ready | ~valid;
  assign line_end  = ({1'b0, cx} + 17'(LANES)) >= {1'b0, video_width};
  assign frame_end = ({1'b0, cy} + 17'd1) >= {1'b0, video_height};
  assign busy      = (state == ST_SCAN);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [16:0]           lane_x;
    logic [PIXEL_BITS-1:0] lane_pixel;

    assign lane_x = {1'b0, cx} + 17'(i);

    pattern_pixel #(
      .PIXEL_BITS(PIXEL_BITS),
      .BOX_SIZE  (BOX_SIZE),
      .BAR_SHIFT (BAR_SHIFT)
    ) u_pixel (
      .x           (lane_x[15:0]),
      .y           (cy),
      .active      (lane_x < {1'b0, video_width}),
      .width       (video_width),
      .height      (video_height),
      .mode        (cfg_mode),
      .solid_colour(cfg_solid),
      .check_shift (cfg_check_shift),
      .ring_enable (cfg_ring),
      .box_x       (box_x),
      .box_y       (box_y),
      .pixel       (lane_pixel)
    );

    assign beat[i*PIXEL_BITS +: PIXEL_BITS] = lane_pixel;
  end

  // Returns {new_dir, new_pos} for one axis; dir 0 means moving towards higher
  // coordinates. Frames too small for the box to move keep it parked at BORDER.
  function automatic logic [16:0] box_next(input logic [15:0] pos, input logic dir,
                                           input logic [15:0] extent);
    if ({1'b0, extent} < 17'(BOX_SIZE + 2*BORDER + BOX_STEP)) begin
      return {1'b0, 16'(BORDER)};
    end else if (!dir) begin
      if (({1'b0, pos} + 17'(BOX_STEP + BOX_SIZE + BORDER)) <= {1'b0, extent})
        return {1'b0, pos + 16'(BOX_STEP)};
      else
        return {1'b1, pos - 16'(BOX_STEP)};
    end else begin
      if (pos >= 16'(BORDER + BOX_STEP))
        return {1'b1, pos - 16'(BOX_STEP)};
      else
        return {1'b0, pos + 16'(BOX_STEP)};
    end
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      cx              <= '0;
      cy              <= '0;
      cfg_mode        <= MODE_SOLID;
      cfg_solid       <= '0;
      cfg_check_shift <= '0;
      cfg_ring        <= 1'b0;
      box_x           <= 16'(BORDER);
      box_y           <= 16'(BORDER);
      dir_x           <= 1'b0;
      dir_y           <= 1'b0;
      valid           <= 1'b0;
      data            <= '0;
      sof             <= 1'b0;
      eol             <= 1'b0;
      frame_count     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (adv) begin
            valid <= 1'b0;
            sof   <= 1'b0;
            eol   <= 1'b0;
          end
          if (start_frame) begin
            cfg_mode        <= mode;
            cfg_solid       <= solid_colour;
            cfg_check_shift <= check_shift;
            cfg_ring        <= ring_enable;
            cx              <= '0;
            cy              <= '0;
            state           <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (adv) begin
            valid <= 1'b1;
            data  <= beat;
            sof   <= (cx == 16'd0) && (cy == 16'd0);
            eol   <= line_end;
            if (!line_end) begin
              cx <= cx + 16'(LANES);
            end else begin
              cx <= '0;
              if (!frame_end) begin
                cy <= cy + 16'd1;
              end else begin
                state          <= ST_IDLE;
                frame_count    <= frame_count + 16'd1;
                {dir_x, box_x} <= box_next(box_x, dir_x, video_width);
                {dir_y, box_y} <= box_next(box_y, dir_y, video_height);
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_generator.sv
// Scoreboard bench for pattern_generator: a frame-level reference model queues
// every expected beat, and a negedge monitor compares whatever the DUT presents.
module tb_pattern_generator;

  localparam int LANES = 4;
  localparam int PB    = 24;
  localparam int DW    = LANES * PB;
  localparam int IW    = DW + 2;

  logic          clock;
  logic          reset_n;
  logic [15:0]   video_width;
  logic [15:0]   video_height;
  logic [1:0]    mode;
  logic [23:0]   solid_colour;
  logic [2:0]    check_shift;
  logic          ring_enable;
  logic          start_frame;
  logic          busy;
  logic          ready;
  logic          valid;
  logic [DW-1:0] data;
  logic          sof;
  logic          eol;
  logic [15:0]   frame_count;

  pattern_generator #(.LANES(LANES), .PIXEL_BITS(PB)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .video_width (video_width),
    .video_height(video_height),
    .mode        (mode),
    .solid_colour(solid_colour),
    .check_shift (check_shift),
    .ring_enable (ring_enable),
    .start_frame (start_frame),
    .busy        (busy),
    .ready       (ready),
    .valid       (valid),
    .data        (data),
    .sof         (sof),
    .eol         (eol),
    .frame_count (frame_count)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [IW-1:0] exp_q[$];
  bit stall_en = 1'b0;

  // reference model state: box position/direction and completed frames
  int m_bx, m_by;
  bit m_dx, m_dy;
  int m_frames;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [23:0] ref_pixel(input int x, input int y, input int w, input int h,
                                            input int md, input logic [23:0] solid,
                                            input int cs, input bit ring);
    logic [23:0] ring_c[4];
    logic [23:0] bars[8];
    int k;
    ring_c = '{24'h0000FF, 24'h00FF00, 24'hFF0000, 24'h000000};
    bars   = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    k = x;
    if (y < k) k = y;
    if (w - 1 - x < k) k = w - 1 - x;
    if (h - 1 - y < k) k = h - 1 - y;
    if (ring && k < 4) return ring_c[k];
    if (md == 3 && x >= m_bx && x < m_bx + 200 && y >= m_by && y < m_by + 200)
      return 24'hFFCC66;
    if (md == 0) return solid;
    if (md == 1) return bars[(x / 32) % 8];
    return ((((x >> cs) ^ (y >> cs)) & 1) != 0) ? 24'hFFFFFF : 24'hCCCCCC;
  endfunction

  function automatic void push_frame(input int w, input int h, input int md,
                                     input logic [23:0] solid, input int cs, input bit ring);
    logic [DW-1:0] d;
    for (int y = 0; y < h; y++) begin
      for (int cx = 0; cx < w; cx += LANES) begin
        d = '0;
        for (int i = 0; i < LANES; i++) begin
          if (cx + i < w) d[i*PB +: PB] = ref_pixel(cx + i, y, w, h, md, solid, cs, ring);
        end
        exp_q.push_back({(cx == 0 && y == 0), (cx + LANES >= w), d});
      end
    end
  endfunction

  function automatic void step_axis(input int pos, input bit dir, input int ext,
                                    output int npos, output bit ndir);
    npos = pos;
    ndir = dir;
    if (ext < 200 + 2*20 + 8) begin
      npos = 20;
      ndir = 1'b0;
    end else if (!dir) begin
      if (pos + 8 + 200 + 20 <= ext) npos = pos + 8;
      else begin npos = pos - 8; ndir = 1'b1; end
    end else begin
      if (pos >= 20 + 8) npos = pos - 8;
      else begin npos = pos + 8; ndir = 1'b0; end
    end
  endfunction

  function automatic void model_reset();
    m_bx = 20; m_by = 20; m_dx = 1'b0; m_dy = 1'b0; m_frames = 0;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (reset_n && valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=%0h required=none", {sof, eol, data});
      end else begin
        check("beat", 128'({sof, eol, data}), 128'(exp_q[0]));
        if (ready) void'(exp_q.pop_front());
      end
    end
  end

  // ready driver: random backpressure while stall_en is set
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int t = 0;
    while (busy && t < 100000) begin @(posedge clock); #1; t++; end
    if (busy) begin
      checks++; errors++;
      $display("FAIL wait_idle actual=busy required=idle");
    end
  endtask

  task automatic start(input int w, input int h, input int md, input logic [23:0] solid,
                       input int cs, input bit ring);
    video_width  = 16'(w);
    video_height = 16'(h);
    mode         = 2'(md);
    solid_colour = solid;
    check_shift  = 3'(cs);
    ring_enable  = ring;
    start_frame  = 1'b1;
    @(posedge clock);
    #1;
    start_frame  = 1'b0;
    mode         = 2'($urandom_range(0, 3));   // config is latched; later changes must not matter
    solid_colour = 24'($urandom);
  endtask

  task automatic run_frame(input int w, input int h, input int md, input logic [23:0] solid,
                           input int cs, input bit ring, input bit stall, input bit check_lat);
    int t = 0;
    int budget;
    int nb;
    bit nd;
    wait_idle();
    stall_en = stall;
    push_frame(w, h, md, solid, cs, ring);
    start(w, h, md, solid, cs, ring);
    check("busy_rise", 128'(busy), 128'(1));
    if (check_lat) begin
      @(posedge clock);
      #1;
      check("latency_valid", 128'(valid), 128'(1));
      check("latency_sof", 128'(sof), 128'(1));
    end
    budget = ((w + LANES - 1) / LANES) * h * 10 + 50;
    while ((exp_q.size() != 0 || busy) && t < budget) begin @(posedge clock); #1; t++; end
    if (exp_q.size() != 0 || busy) begin
      checks++; errors++;
      $display("FAIL frame_timeout actual=%0d_beats_left required=0", exp_q.size());
      exp_q.delete();
    end
    stall_en = 1'b0;
    m_frames = (m_frames + 1) % 65536;
    step_axis(m_bx, m_dx, w, nb, nd); m_bx = nb; m_dx = nd;
    step_axis(m_by, m_dy, h, nb, nd); m_by = nb; m_dy = nd;
    check("frame_count", 128'(frame_count), 128'(m_frames));
    check("busy_idle", 128'(busy), 128'(0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 128'(valid), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_sof"}, 128'(sof), 128'(0));
    check({tag, "_eol"}, 128'(eol), 128'(0));
    check({tag, "_data"}, 128'(data), 128'(0));
    check({tag, "_frame_count"}, 128'(frame_count), 128'(0));
  endtask

  task automatic reset_mid_frame();
    wait_idle();
    push_frame(64, 8, 2, 24'h0, 2, 1'b1);
    start(64, 8, 2, 24'h0, 2, 1'b1);
    repeat (20) begin @(posedge clock); #1; end
    check("pre_reset_busy", 128'(busy), 128'(1));
    check("pre_reset_valid", 128'(valid), 128'(1));
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    model_reset();
    check_reset_values("async_reset");
    repeat (3) begin @(posedge clock); #1; end
    reset_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n      = 1'b0;
    start_frame  = 1'b0;
    video_width  = 16'd8;
    video_height = 16'd2;
    mode         = 2'd0;
    solid_colour = 24'h0;
    check_shift  = 3'd0;
    ring_enable  = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_reset_values("reset");
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    run_frame(8, 2, 0, 24'h123456, 0, 1'b0, 1'b0, 1'b1);
    run_frame(64, 1, 1, 24'h0, 0, 1'b0, 1'b0, 1'b1);
    run_frame(10, 1, 2, 24'h0, 1, 1'b0, 1'b0, 1'b1);
    run_frame(10, 3, 2, 24'h0, 1, 1'b0, 1'b1, 1'b0);
    run_frame(64, 4, 1, 24'h0, 0, 1'b1, 1'b1, 1'b0);

    for (int f = 0; f < 3; f++) run_frame(256, 256, 3, 24'h0, 4, 1'b1, 1'b0, 1'b0);

    reset_mid_frame();
    run_frame(16, 2, 0, 24'hA5C3E1, 0, 1'b0, 1'b0, 1'b1);

    for (int n = 0; n < 12; n++) begin
      run_frame($urandom_range(LANES, 40), $urandom_range(1, 24), $urandom_range(0, 3),
                24'($urandom), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (5) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
